pipeline_id_ex: RTL and testbench
=================================

// Module: pipeline_id_ex
// PURPOSE
//  Parametrised decode stage for the 5-stage MIPS pipeline: register file, WB write-through,
//  MEM->ID bypass, load-use and branch-operand interlocks, early branch/jr resolution, and an
//  owned ID/EX pipeline register with valid/ready handshake, flush and a stall counter.
//  Sits between the IF/ID register (upstream, holds instr while if_ready=0) and the EX stage.
// PARAMETERS
//  XLEN     32  datapath width
//  NREG     32  architectural registers; reg 0 reads as 0, writes ignored
//  AW       5   register index width, = $clog2(NREG)
//  CNT_W    16  stall counter width
// PORTS
//  clk          in   1     clock, all state updates on rising edge
//  reset        in   1     synchronous, active-low reset
//  if_valid     in   1     IF/ID holds a valid instruction
//  if_ready     out  1     ID accepts the instruction this cycle
//  if_pc        in   XLEN  PC+4 of the instruction
//  if_instr     in   32    instruction word
//  flush        in   1     IRQ/exception kill of ID and ID/EX contents
//  ex_ready     in   1     EX consumes the ID/EX contents this cycle
//  ex_wr,ex_load,ex_dst  in 1,1,AW    producer in EX: writes reg, is load, dest
//  mem_wr,mem_load,mem_dst,mem_data in 1,1,AW,XLEN  producer in MEM
//  wb_we,wb_addr,wb_data in 1,AW,XLEN WB write port
//  br_taken     out  1     branch/jump resolved taken in ID this cycle
//  br_target    out  XLEN  target: ConBA, {pc[31:28],JT,2'b0} or rs (jr/jalr)
//  idex_valid   out  1     ID/EX holds valid instruction
//  idex_pc,idex_instr,idex_a,idex_b  out XLEN,32,XLEN,XLEN  registered PC, instr, operands
//  idex_dst     out  AW    rd for R-type, rt for I-type, 31 for jal
//  stall_cnt    out  CNT_W saturating count of interlock cycles
// BEHAVIOUR
//  Reset (reset=0 at edge): RF all 0, idex_* all 0, idex_valid=0, stall_cnt=0. Reset overrides
//   flush and WB write in the same cycle.
//  RF: write at edge when wb_we && wb_addr!=0. Read combinational; if wb_we && wb_addr==src && src!=0
//   read returns wb_data (write-through). Index >= NREG reads 0.
//  Operand select (a/b): src==0 -> 0; mem_wr && !mem_load && mem_dst==src -> mem_data; else RF/WB.
//  Source use: R-type rs+rt; beq/bne, stores rs+rt; bltz/blez/bgtz, I-ALU, loads, jr/jalr rs;
//   j/jal/lui none. Unused sources never cause interlocks.
//  hz_load: ex_load && ex_wr && ex_dst!=0 && ex_dst matches a used source.
//  hz_br (branch or jr/jalr only): (ex_wr && ex_dst!=0 && match) || (mem_load && mem_dst!=0 && match).
//  stall = if_valid && (hz_load || hz_br).
//  if_ready = !stall && (!idex_valid || ex_ready) && !flush.
//  Edge update, priority: flush -> idex_valid<=0; else if if_valid && if_ready -> load ID/EX,
//   idex_valid<=1; else if ex_ready -> idex_valid<=0 (bubble); else hold.
//  br_taken = if_valid && !stall && !flush && (beq a==b | bne a!=b | bltz a<0 | blez a<=0 |
//   bgtz a>0 | j | jal | jr | jalr); signed compares on XLEN. Combinational, 0 cycles latency.
//  ConBA = if_pc + (sext(imm16)<<2), mod 2^XLEN wrap. jal/jalr: idex_a <= if_pc (link value).
//  Branch issue latency 0; load-use adds 1 bubble; branch on EX ALU result 1 stall, on EX load 2.
//  stall_cnt += 1 each cycle stall=1, saturates at 2^CNT_W-1, does not wrap.
//  Simultaneous flush and stall: flush wins, stall_cnt still counts.
//  Mid-op reset: pipeline register and counter cleared next edge regardless of handshake.
// STRUCTURE
//  Shared package mips_pkg: opcode/funct localparams (OP_RTYPE, OP_BLTZ=1, OP_J=2, OP_JAL=3,
//   OP_BEQ..OP_BGTZ=4..7, F_JR=8, F_JALR=9), source-use decode function, XLEN default.
//  One sub-module: id_regfile (NREG x XLEN, 2R1W, write-through, sync active-low reset).
//  Hazard, bypass, branch compare and ID/EX register live in this module.
// TESTING
//  1 WB write r5=0x1234 same cycle as ID reads r5 -> idex_a=0x1234; write r0=7 -> reads 0.
//  2 lw r8 in EX, add r9,r8,r1 in ID -> if_ready=0 one cycle, bubble (idex_valid=0), stall_cnt=1.
//  3 add r3 in MEM (mem_data=5), beq r3,r4 with r4=5 -> br_taken=1, br_target=pc+4+(imm<<2).
//  4 lw r3 in EX, beq r3,r0 -> 2 stall cycles then resolves; stall_cnt=2.
//  5 bltz with a=0x80000000 taken; bgtz a=0 not taken; imm=0x8000 -> target pc-0x20000.
//  6 flush with stall and ex_ready=0 -> idex_valid=0 next edge; reset=0 mid-stall clears all outputs.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode/funct encodings, branch classes and
// the source-register usage decoder used by the ID stage interlocks.
package mips_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BLTZ  = 6'd1;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_BLEZ  = 6'd6;
    localparam logic [5:0] OP_BGTZ  = 6'd7;
    localparam logic [5:0] OP_LUI   = 6'd15;

    localparam logic [5:0] F_JR     = 6'd8;
    localparam logic [5:0] F_JALR   = 6'd9;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQ   = 3'd1,
        BR_NE   = 3'd2,
        BR_LTZ  = 3'd3,
        BR_LEZ  = 3'd4,
        BR_GTZ  = 3'd5,
        BR_J    = 3'd6,
        BR_JR   = 3'd7
    } br_kind_t;

    typedef struct packed {
        logic use_rs;
        logic use_rt;
    } src_use_t;

    // Which register fields an instruction actually reads; unused fields must
    // never raise an interlock.
    function automatic src_use_t src_use(input logic [31:0] instr);
        src_use_t u;
        u.use_rs = 1'b0;
        u.use_rt = 1'b0;
        case (instr[31:26])
            OP_RTYPE: begin
                if (instr[5:0] == F_JR || instr[5:0] == F_JALR) begin
                    u.use_rs = 1'b1;
                end else begin
                    u.use_rs = 1'b1;
                    u.use_rt = 1'b1;
                end
            end
            OP_BEQ, OP_BNE: begin
                u.use_rs = 1'b1;
                u.use_rt = 1'b1;
            end
            OP_BLTZ, OP_BLEZ, OP_BGTZ: u.use_rs = 1'b1;
            OP_J, OP_JAL, OP_LUI:      u.use_rs = 1'b0;
            default: begin
                case (instr[31:29])
                    3'b001:  u.use_rs = 1'b1;           // I-type ALU
                    3'b100:  u.use_rs = 1'b1;           // loads
                    3'b101: begin                       // stores
                        u.use_rs = 1'b1;
                        u.use_rt = 1'b1;
                    end
                    default: u.use_rs = 1'b0;
                endcase
            end
        endcase
        return u;
    endfunction

    function automatic br_kind_t br_kind(input logic [31:0] instr);
        br_kind_t k;
        k = BR_NONE;
        case (instr[31:26])
            OP_RTYPE: begin
                if (instr[5:0] == F_JR || instr[5:0] == F_JALR) begin
                    k = BR_JR;
                end else begin
                    k = BR_NONE;
                end
            end
            OP_J, OP_JAL: k = BR_J;
            OP_BEQ:       k = BR_EQ;
            OP_BNE:       k = BR_NE;
            OP_BLTZ:      k = BR_LTZ;
            OP_BLEZ:      k = BR_LEZ;
            OP_BGTZ:      k = BR_GTZ;
            default:      k = BR_NONE;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// Decode-stage register file: NREG x XLEN, two combinational read ports with
// write-through from the single WB write port; register 0 is hardwired to zero.
module id_regfile
    import mips_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr_a,
    input  logic [AW-1:0]   raddr_b,
    output logic [XLEN-1:0] rdata_a,
    output logic [XLEN-1:0] rdata_b
);

    logic [XLEN-1:0] rf_r [NREG];

    // Register storage: cleared by reset, written from WB except into r0
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                rf_r[i] <= {XLEN{1'b0}};
            end
        end else if (we && waddr != {AW{1'b0}} && int'(waddr) < NREG) begin
            rf_r[waddr] <= wdata;
        end else begin
            rf_r[waddr] <= rf_r[waddr];
        end
    end

    // Read port A with write-through so WB results are visible in the same cycle
    always_comb begin
        rdata_a = {XLEN{1'b0}};
        if (raddr_a == {AW{1'b0}} || int'(raddr_a) >= NREG) begin
            rdata_a = {XLEN{1'b0}};
        end else if (we && waddr == raddr_a) begin
            rdata_a = wdata;
        end else begin
            rdata_a = rf_r[raddr_a];
        end
    end

    // Read port B, same rules as port A
    always_comb begin
        rdata_b = {XLEN{1'b0}};
        if (raddr_b == {AW{1'b0}} || int'(raddr_b) >= NREG) begin
            rdata_b = {XLEN{1'b0}};
        end else if (we && waddr == raddr_b) begin
            rdata_b = wdata;
        end else begin
            rdata_b = rf_r[raddr_b];
        end
    end

endmodule

// File: rtl/pipeline_id_ex.sv
// MIPS decode stage: operand fetch with MEM bypass, load-use and branch-operand
// interlocks, early branch/jump resolution and the ID/EX pipeline register.
module pipeline_id_ex
    import mips_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREG  = 32,
    parameter int AW    = $clog2(NREG),
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [XLEN-1:0]  if_pc,
    input  logic [31:0]      if_instr,
    input  logic             flush,
    input  logic             ex_ready,
    input  logic             ex_wr,
    input  logic             ex_load,
    input  logic [AW-1:0]    ex_dst,
    input  logic             mem_wr,
    input  logic             mem_load,
    input  logic [AW-1:0]    mem_dst,
    input  logic [XLEN-1:0]  mem_data,
    input  logic             wb_we,
    input  logic [AW-1:0]    wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    output logic             br_taken,
    output logic [XLEN-1:0]  br_target,
    output logic             idex_valid,
    output logic [XLEN-1:0]  idex_pc,
    output logic [31:0]      idex_instr,
    output logic [XLEN-1:0]  idex_a,
    output logic [XLEN-1:0]  idex_b,
    output logic [AW-1:0]    idex_dst,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [AW-1:0] REG_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] REG_RA   = AW'(5'd31);

    logic [AW-1:0]    rs_s, rt_s, rd_s, dst_s;
    logic [XLEN-1:0]  rf_a_s, rf_b_s, op_a_s, op_b_s;
    logic [XLEN-1:0]  conba_s, jta_s, target_s;
    src_use_t         use_s;
    br_kind_t         kind_s;
    logic             is_link_s, cond_s;
    logic             match_ex_s, match_mem_s, hz_load_s, hz_br_s, stall_s, if_ready_s;

    logic             idex_valid_r;
    logic [XLEN-1:0]  idex_pc_r, idex_a_r, idex_b_r;
    logic [31:0]      idex_instr_r;
    logic [AW-1:0]    idex_dst_r;
    logic [CNT_W-1:0] stall_cnt_r;

    assign rs_s   = AW'(if_instr[25:21]);
    assign rt_s   = AW'(if_instr[20:16]);
    assign rd_s   = AW'(if_instr[15:11]);
    assign use_s  = src_use(if_instr);
    assign kind_s = br_kind(if_instr);
    assign is_link_s = (if_instr[31:26] == OP_JAL) ||
                       (if_instr[31:26] == OP_RTYPE && if_instr[5:0] == F_JALR);

    id_regfile #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (wb_we),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (rs_s),
        .raddr_b (rt_s),
        .rdata_a (rf_a_s),
        .rdata_b (rf_b_s)
    );

    // Operand A: MEM ALU result is newer than anything in RF/WB
    always_comb begin
        op_a_s = rf_a_s;
        if (rs_s == REG_ZERO) begin
            op_a_s = {XLEN{1'b0}};
        end else if (mem_wr && !mem_load && mem_dst == rs_s) begin
            op_a_s = mem_data;
        end else begin
            op_a_s = rf_a_s;
        end
    end

    // Operand B, same bypass rules as operand A
    always_comb begin
        op_b_s = rf_b_s;
        if (rt_s == REG_ZERO) begin
            op_b_s = {XLEN{1'b0}};
        end else if (mem_wr && !mem_load && mem_dst == rt_s) begin
            op_b_s = mem_data;
        end else begin
            op_b_s = rf_b_s;
        end
    end

    // Interlocks: load-use always; branches also wait for EX results and MEM loads
    always_comb begin
        match_ex_s  = (ex_dst != REG_ZERO) &&
                      ((use_s.use_rs && ex_dst == rs_s) || (use_s.use_rt && ex_dst == rt_s));
        match_mem_s = (mem_dst != REG_ZERO) &&
                      ((use_s.use_rs && mem_dst == rs_s) || (use_s.use_rt && mem_dst == rt_s));
        hz_load_s   = ex_load && ex_wr && match_ex_s;
        if (kind_s != BR_NONE) begin
            hz_br_s = (ex_wr && match_ex_s) || (mem_load && match_mem_s);
        end else begin
            hz_br_s = 1'b0;
        end
        stall_s = if_valid && (hz_load_s || hz_br_s);
    end

    assign conba_s = if_pc + {{(XLEN-18){if_instr[15]}}, if_instr[15:0], 2'b00};
    assign jta_s   = {if_pc[XLEN-1:28], if_instr[25:0], 2'b00};

    // Branch condition and target selection on the bypassed operands
    always_comb begin
        cond_s   = 1'b0;
        target_s = conba_s;
        case (kind_s)
            BR_EQ:  cond_s = (op_a_s == op_b_s);
            BR_NE:  cond_s = (op_a_s != op_b_s);
            BR_LTZ: cond_s = op_a_s[XLEN-1];
            BR_LEZ: cond_s = op_a_s[XLEN-1] || (op_a_s == {XLEN{1'b0}});
            BR_GTZ: cond_s = !op_a_s[XLEN-1] && (op_a_s != {XLEN{1'b0}});
            BR_J: begin
                cond_s   = 1'b1;
                target_s = jta_s;
            end
            BR_JR: begin
                cond_s   = 1'b1;
                target_s = op_a_s;
            end
            default: begin
                cond_s   = 1'b0;
                target_s = conba_s;
            end
        endcase
    end

    // Destination register: rd for R-type, $ra for jal, rt otherwise
    always_comb begin
        dst_s = rt_s;
        if (if_instr[31:26] == OP_RTYPE) begin
            dst_s = rd_s;
        end else if (if_instr[31:26] == OP_JAL) begin
            dst_s = REG_RA;
        end else begin
            dst_s = rt_s;
        end
    end

    assign if_ready_s = !stall_s && (!idex_valid_r || ex_ready) && !flush;
    assign if_ready   = if_ready_s;
    assign br_taken   = if_valid && !stall_s && !flush && cond_s;
    assign br_target  = target_s;

    // ID/EX register: flush kills, accepted instruction loads, consumed entry becomes a bubble
    always_ff @(posedge clk) begin
        if (!reset) begin
            idex_valid_r <= 1'b0;
            idex_pc_r    <= {XLEN{1'b0}};
            idex_instr_r <= 32'h0000_0000;
            idex_a_r     <= {XLEN{1'b0}};
            idex_b_r     <= {XLEN{1'b0}};
            idex_dst_r   <= REG_ZERO;
        end else if (flush) begin
            idex_valid_r <= 1'b0;
        end else if (if_valid && if_ready_s) begin
            idex_valid_r <= 1'b1;
            idex_pc_r    <= if_pc;
            idex_instr_r <= if_instr;
            idex_a_r     <= is_link_s ? if_pc : op_a_s;
            idex_b_r     <= op_b_s;
            idex_dst_r   <= dst_s;
        end else if (ex_ready) begin
            idex_valid_r <= 1'b0;
        end else begin
            idex_valid_r <= idex_valid_r;
        end
    end

    // Saturating interlock counter; counts even when a flush overrides the stall
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && stall_cnt_r != {CNT_W{1'b1}}) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign idex_valid = idex_valid_r;
    assign idex_pc    = idex_pc_r;
    assign idex_instr = idex_instr_r;
    assign idex_a     = idex_a_r;
    assign idex_b     = idex_b_r;
    assign idex_dst   = idex_dst_r;
    assign stall_cnt  = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_id_ex.sv
// Directed bench for pipeline_id_ex: forwarding, interlocks, branch resolution,
// flush/reset, plus a narrow-counter instance sharing the stimulus for saturation.
module tb_pipeline_id_ex;

    logic        clk = 1'b0;
    logic        reset, if_valid, flush, ex_ready;
    logic [31:0] if_pc, if_instr, mem_data, wb_data;
    logic        ex_wr, ex_load, mem_wr, mem_load, wb_we;
    logic [4:0]  ex_dst, mem_dst, wb_addr;

    logic        if_ready, br_taken, idex_valid;
    logic [31:0] br_target, idex_pc, idex_instr, idex_a, idex_b;
    logic [4:0]  idex_dst;
    logic [15:0] stall_cnt;

    logic        s_if_ready, s_br_taken, s_idex_valid;
    logic [31:0] s_br_target, s_idex_pc, s_idex_instr, s_idex_a, s_idex_b;
    logic [4:0]  s_idex_dst;
    logic [1:0]  s_stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipeline_id_ex dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(if_ready),
        .if_pc(if_pc), .if_instr(if_instr), .flush(flush), .ex_ready(ex_ready),
        .ex_wr(ex_wr), .ex_load(ex_load), .ex_dst(ex_dst),
        .mem_wr(mem_wr), .mem_load(mem_load), .mem_dst(mem_dst), .mem_data(mem_data),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .br_taken(br_taken), .br_target(br_target), .idex_valid(idex_valid),
        .idex_pc(idex_pc), .idex_instr(idex_instr), .idex_a(idex_a), .idex_b(idex_b),
        .idex_dst(idex_dst), .stall_cnt(stall_cnt)
    );

    pipeline_id_ex #(.CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(s_if_ready),
        .if_pc(if_pc), .if_instr(if_instr), .flush(flush), .ex_ready(ex_ready),
        .ex_wr(ex_wr), .ex_load(ex_load), .ex_dst(ex_dst),
        .mem_wr(mem_wr), .mem_load(mem_load), .mem_dst(mem_dst), .mem_data(mem_data),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .br_taken(s_br_taken), .br_target(s_br_target), .idex_valid(s_idex_valid),
        .idex_pc(s_idex_pc), .idex_instr(s_idex_instr), .idex_a(s_idex_a), .idex_b(s_idex_b),
        .idex_dst(s_idex_dst), .stall_cnt(s_stall_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic clear_prod();
        ex_wr = 1'b0; ex_load = 1'b0; ex_dst = 5'd0;
        mem_wr = 1'b0; mem_load = 1'b0; mem_dst = 5'd0; mem_data = 32'h0;
        wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    endtask

    initial begin
        reset = 1'b0; if_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        if_pc = 32'h0; if_instr = 32'h0;
        clear_prod();
        tick(); tick();
        check("rst_valid", idex_valid, 64'd0);
        check("rst_pc", idex_pc, 64'd0);
        check("rst_a", idex_a, 64'd0);
        check("rst_cnt", stall_cnt, 64'd0);
        reset = 1'b1;

        // WB write-through into the same-cycle read
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
        if_valid = 1'b1; if_pc = 32'h100; if_instr = i_ins(6'h08, 5'd5, 5'd6, 16'h0001);
        #1 check("wt_ready", if_ready, 64'd1);
        tick();
        check("wt_valid", idex_valid, 64'd1);
        check("wt_a", idex_a, 64'h1234);
        check("wt_dst", idex_dst, 64'd6);
        check("wt_pc", idex_pc, 64'h100);
        wb_addr = 5'd0; wb_data = 32'h7;
        if_pc = 32'h104; if_instr = r_ins(5'd0, 5'd5, 5'd7, 6'h20);
        tick();
        check("r0_read", idex_a, 64'd0);
        check("rf_hold", idex_b, 64'h1234);
        if_valid = 1'b0; wb_addr = 5'd4; wb_data = 32'd5;
        tick();
        wb_we = 1'b0;

        // Load-use: one bubble then issue
        ex_wr = 1'b1; ex_load = 1'b1; ex_dst = 5'd8;
        if_valid = 1'b1; if_pc = 32'h200; if_instr = r_ins(5'd8, 5'd1, 5'd9, 6'h20);
        #1 check("lu_ready", if_ready, 64'd0);
        tick();
        check("lu_bubble", idex_valid, 64'd0);
        check("lu_cnt", stall_cnt, 64'd1);
        clear_prod();
        mem_wr = 1'b1; mem_load = 1'b1; mem_dst = 5'd8;
        #1 check("lu_ready2", if_ready, 64'd1);
        tick();
        check("lu_issue", idex_valid, 64'd1);
        check("lu_dst", idex_dst, 64'd9);
        check("lu_cnt2", stall_cnt, 64'd1);

        // MEM bypass into beq
        clear_prod();
        mem_wr = 1'b1; mem_dst = 5'd3; mem_data = 32'd5;
        if_pc = 32'h1000; if_instr = i_ins(6'd4, 5'd3, 5'd4, 16'h0010);
        #1 check("beq_taken", br_taken, 64'd1);
        check("beq_target", br_target, 64'h1040);
        check("beq_ready", if_ready, 64'd1);
        tick();
        check("beq_a", idex_a, 64'd5);
        check("beq_b", idex_b, 64'd5);
        if_instr = i_ins(6'd5, 5'd3, 5'd4, 16'h0010);
        #1 check("bne_nt", br_taken, 64'd0);
        tick();

        // Branch on a load in EX: two stall cycles
        clear_prod();
        ex_wr = 1'b1; ex_load = 1'b1; ex_dst = 5'd3;
        if_pc = 32'h2000; if_instr = i_ins(6'd5, 5'd3, 5'd0, 16'h0004);
        #1 check("bl_ready1", if_ready, 64'd0);
        check("bl_taken1", br_taken, 64'd0);
        tick();
        check("bl_cnt1", stall_cnt, 64'd2);
        check("bl_bubble", idex_valid, 64'd0);
        clear_prod();
        mem_wr = 1'b1; mem_load = 1'b1; mem_dst = 5'd3; mem_data = 32'hdead;
        #1 check("bl_ready2", if_ready, 64'd0);
        check("bl_taken2", br_taken, 64'd0);
        tick();
        check("bl_cnt2", stall_cnt, 64'd3);
        clear_prod();
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h77;
        #1 check("bl_taken3", br_taken, 64'd1);
        check("bl_target", br_target, 64'h2010);
        check("bl_ready3", if_ready, 64'd1);
        tick();
        check("bl_cnt3", stall_cnt, 64'd3);
        check("bl_a", idex_a, 64'h77);
        check("sat_cnt3", s_stall_cnt, 64'd3);

        // Sign compares, negative offset, jumps and link
        clear_prod();
        mem_wr = 1'b1; mem_dst = 5'd10; mem_data = 32'h8000_0000;
        if_pc = 32'h30000; if_instr = i_ins(6'd1, 5'd10, 5'd0, 16'h8000);
        #1 check("bltz_taken", br_taken, 64'd1);
        check("bltz_target", br_target, 64'h10000);
        if_instr = i_ins(6'd7, 5'd0, 5'd0, 16'h0004);
        #1 check("bgtz_zero", br_taken, 64'd0);
        if_instr = i_ins(6'd6, 5'd0, 5'd0, 16'h0004);
        #1 check("blez_zero", br_taken, 64'd1);
        if_pc = 32'hA000_0004; if_instr = {6'd3, 26'h0000100};
        #1 check("jal_taken", br_taken, 64'd1);
        check("jal_target", br_target, 64'hA000_0400);
        tick();
        check("jal_link", idex_a, 64'hA000_0004);
        check("jal_dst", idex_dst, 64'd31);
        if_pc = 32'h50; if_instr = r_ins(5'd10, 5'd0, 5'd0, 6'h08);
        #1 check("jr_target", br_target, 64'h8000_0000);
        check("jr_taken", br_taken, 64'd1);
        ex_wr = 1'b1; ex_dst = 5'd10;
        #1 check("jr_ex_ready", if_ready, 64'd0);
        check("jr_ex_taken", br_taken, 64'd0);
        tick();
        check("jr_cnt", stall_cnt, 64'd4);
        check("sat_hold", s_stall_cnt, 64'd3);
        clear_prod();
        ex_wr = 1'b1; ex_load = 1'b1; ex_dst = 5'd8;
        if_pc = 32'h40; if_instr = {6'd2, 5'd8, 21'd0};
        #1 check("j_unused_src", if_ready, 64'd1);
        check("j_target", br_target, 64'h0400_0000);
        tick();
        check("j_cnt", stall_cnt, 64'd4);

        // Flush beats a stall while EX is blocked
        clear_prod();
        if_pc = 32'h500; if_instr = r_ins(5'd1, 5'd2, 5'd9, 6'h20);
        tick();
        check("fl_pre", idex_valid, 64'd1);
        ex_ready = 1'b0; flush = 1'b1;
        ex_wr = 1'b1; ex_load = 1'b1; ex_dst = 5'd1;
        #1 check("fl_ready", if_ready, 64'd0);
        tick();
        check("fl_valid", idex_valid, 64'd0);
        check("fl_cnt", stall_cnt, 64'd5);
        flush = 1'b0; ex_ready = 1'b1; clear_prod();
        if_pc = 32'h600;
        tick();
        check("re_valid", idex_valid, 64'd1);
        check("re_pc", idex_pc, 64'h600);
        if_valid = 1'b0; ex_ready = 1'b0;
        tick();
        check("hold_valid", idex_valid, 64'd1);

        // Reset in the middle of a stall
        if_valid = 1'b1; ex_wr = 1'b1; ex_load = 1'b1; ex_dst = 5'd1;
        reset = 1'b0;
        tick();
        check("mr_valid", idex_valid, 64'd0);
        check("mr_pc", idex_pc, 64'd0);
        check("mr_instr", idex_instr, 64'd0);
        check("mr_a", idex_a, 64'd0);
        check("mr_cnt", stall_cnt, 64'd0);
        reset = 1'b1; clear_prod(); ex_ready = 1'b1;
        if_pc = 32'h700; if_instr = r_ins(5'd4, 5'd3, 5'd11, 6'h20);
        tick();
        check("mr_rf_a", idex_a, 64'd0);
        check("mr_rf_b", idex_b, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
